// File: rtl/fp_mul_pkg.sv
// Shared constants, FSM state encoding and binary32 field layout for the
// single-precision multiply front-end.
package fp_mul_pkg;

  localparam int EXP_W   = 8;
  localparam int MANT_W  = 24;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 254;
  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    ADJ,
    DONE
  } state_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  function automatic fp32_t unpack_fp32(input logic [31:0] raw);
    return fp32_t'(raw);
  endfunction

endpackage

// File: rtl/fp_mul_mantissa_core_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
// done_o is high during the final iteration so the parent can step on that edge.
module mant_shift_add_mul
  import fp_mul_pkg::*;
#(
  parameter int W = MANT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2*W-1:0]   product_o
);

  localparam int CW = $clog2(W);

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;

  always_comb begin
    acc_d = acc_q;
    if (b_q[cnt_q]) begin
      acc_d = acc_q + ({{W{1'b0}}, a_q} << cnt_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == CW'(W - 1));
  assign product_o = acc_q;

endmodule

// File: rtl/fp_mul_mantissa_core.sv
// Multiply front-end: unpacks operands, sums exponents, runs the mantissa
// multiplier and pre-adjusts the product so its leading one sits at bit 46.
module fp_mul_mantissa_core
  import fp_mul_pkg::*;
#(
  parameter int EXP_W  = fp_mul_pkg::EXP_W,
  parameter int MANT_W = fp_mul_pkg::MANT_W,
  parameter int BIAS   = fp_mul_pkg::BIAS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           in_a_i,
  input  logic [31:0]           in_b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_s_o,
  output logic [EXP_W-1:0]      out_e_o,
  output logic [2*MANT_W-1:0]   out_m_o,
  output logic                  out_zero_o,
  output logic                  out_ovf_o,
  output logic                  out_unf_o
);

  localparam int PW = 2 * MANT_W;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] EXP_MIN_S = EW'(1);

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 out_s_q;
  logic [EXP_W-1:0]     out_e_q;
  logic [PW-1:0]        out_m_q;
  logic                 out_zero_q;
  logic                 out_ovf_q;
  logic                 out_unf_q;
  logic                 sign_q;
  logic signed [EW-1:0] esum_q;

  fp32_t                opA;
  fp32_t                opB;
  logic                 sign_d;
  logic signed [EW-1:0] esum_d;
  logic                 opZero;
  logic                 opSpecial;
  logic                 mulStart;
  logic                 mulBusy;
  logic                 mulDone;
  logic [PW-1:0]        product;
  logic signed [EW-1:0] expAdj;
  logic [PW-1:0]        mantAdj;

  assign opA       = unpack_fp32(in_a_i);
  assign opB       = unpack_fp32(in_b_i);
  assign sign_d    = opA.sign ^ opB.sign;
  assign esum_d    = $signed(EW'(opA.exp)) + $signed(EW'(opB.exp)) - $signed(EW'(BIAS));
  assign opZero    = (opA.exp == 8'd0) || (opB.exp == 8'd0);
  assign opSpecial = (opA.exp == EXP_SPECIAL) || (opB.exp == EXP_SPECIAL);
  assign mulStart  = (state_q == IDLE) && in_valid_i && !opZero && !opSpecial;

  mant_shift_add_mul #(
    .W (MANT_W)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (mulStart),
    .a_i       ({1'b1, opA.frac}),
    .b_i       ({1'b1, opB.frac}),
    .busy_o    (mulBusy),
    .done_o    (mulDone),
    .product_o (product)
  );

  // A product with bit 47 set is halved so the normaliser always sees bit 46 as the leading one.
  assign expAdj  = esum_q + $signed({{(EW-1){1'b0}}, product[PW-1]});
  assign mantAdj = product[PW-1] ? (product >> 1) : product;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_s_q     <= 1'b0;
      out_e_q     <= '0;
      out_m_q     <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      sign_q      <= 1'b0;
      esum_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            sign_q     <= sign_d;
            esum_q     <= esum_d;
            in_ready_q <= 1'b0;
            if (opZero) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_s_q     <= sign_d;
              out_e_q     <= '0;
              out_m_q     <= '0;
              out_zero_q  <= 1'b1;
              out_ovf_q   <= 1'b0;
              out_unf_q   <= 1'b0;
            end else if (opSpecial) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_s_q     <= sign_d;
              out_e_q     <= EXP_W'(EXP_SPECIAL);
              out_m_q     <= '0;
              out_zero_q  <= 1'b0;
              out_ovf_q   <= 1'b1;
              out_unf_q   <= 1'b0;
            end else begin
              state_q <= MUL;
            end
          end
        end
        MUL: begin
          if (mulDone || !mulBusy) begin
            state_q <= ADJ;
          end
        end
        ADJ: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
          out_s_q     <= sign_q;
          out_zero_q  <= 1'b0;
          if (expAdj > EXP_MAX_S) begin
            out_ovf_q <= 1'b1;
            out_unf_q <= 1'b0;
            out_e_q   <= EXP_W'(EXP_SPECIAL);
            out_m_q   <= '0;
          end else if (expAdj < EXP_MIN_S) begin
            out_ovf_q <= 1'b0;
            out_unf_q <= 1'b1;
            out_e_q   <= '0;
            out_m_q   <= '0;
          end else begin
            out_ovf_q <= 1'b0;
            out_unf_q <= 1'b0;
            out_e_q   <= expAdj[EXP_W-1:0];
            out_m_q   <= mantAdj;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_s_o     = out_s_q;
  assign out_e_o     = out_e_q;
  assign out_m_o     = out_m_q;
  assign out_zero_o  = out_zero_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_unf_o   = out_unf_q;

endmodule

// File: tb/tb_fp_mul_mantissa_core.sv
// Randomised and directed checks of the multiply front-end against an
// arithmetic reference model of sign, exponent sum and mantissa product.
module tb_fp_mul_mantissa_core;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inReady;
  logic [31:0] inA;
  logic [31:0] inB;
  logic        outValid;
  logic        outReady;
  logic        outS;
  logic [7:0]  outE;
  logic [47:0] outM;
  logic        outZero;
  logic        outOvf;
  logic        outUnf;

  int assertCount = 0;
  int failCount   = 0;

  logic        expS;
  logic [7:0]  expE;
  logic [47:0] expM;
  logic        expZ;
  logic        expO;
  logic        expU;
  int          expLat;

  fp_mul_mantissa_core dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .in_a_i      (inA),
    .in_b_i      (inB),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_s_o     (outS),
    .out_e_o     (outE),
    .out_m_o     (outM),
    .out_zero_o  (outZero),
    .out_ovf_o   (outOvf),
    .out_unf_o   (outUnf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: real-number rules applied with plain integer arithmetic.
  task automatic computeModel(input logic [31:0] a, input logic [31:0] b);
    int                ea;
    int                eb;
    int                e;
    longint unsigned   prod;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    expS = a[31] ^ b[31];
    expE = 8'd0;
    expM = 48'd0;
    expZ = 1'b0;
    expO = 1'b0;
    expU = 1'b0;
    if (ea == 0 || eb == 0) begin
      expZ   = 1'b1;
      expLat = 1;
    end else if (ea == 255 || eb == 255) begin
      expO   = 1'b1;
      expE   = 8'hFF;
      expLat = 1;
    end else begin
      expLat = 26;
      prod = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
      e    = ea + eb - 127;
      if (prod >= 64'h0000_8000_0000_0000) begin
        prod = prod / 2;
        e    = e + 1;
      end
      if (e > 254) begin
        expO = 1'b1;
        expE = 8'hFF;
      end else if (e < 1) begin
        expU = 1'b1;
      end else begin
        expE = e[7:0];
        expM = prod[47:0];
      end
    end
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, "/valid"}, outValid, 1'b1);
    checkOutput({tag, "/s"}, outS, expS);
    checkOutput({tag, "/e"}, outE, expE);
    checkOutput({tag, "/m"}, outM, expM);
    checkOutput({tag, "/zero"}, outZero, expZ);
    checkOutput({tag, "/ovf"}, outOvf, expO);
    checkOutput({tag, "/unf"}, outUnf, expU);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput({tag, "/valid after transfer"}, outValid, 1'b0);
    checkOutput({tag, "/ready after transfer"}, inReady, 1'b1);
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input string tag, input bit doHandshake);
    int edges;
    computeModel(a, b);
    @(negedge clk);
    checkOutput({tag, "/in_ready"}, inReady, 1'b1);
    inA     = a;
    inB     = b;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    edges   = 1;
    while (!outValid && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, "/latency"}, 64'(edges), 64'(expLat));
    checkResult(tag);
    if (!expZ && !expO && !expU) begin
      checkOutput({tag, "/m47"}, outM[47], 1'b0);
      checkOutput({tag, "/m46"}, outM[46], 1'b1);
    end
    if (doHandshake) begin
      handshake(tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rstN     = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    inA      = '0;
    inB      = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset/valid", outValid, 1'b0);
    checkOutput("reset/ready", inReady, 1'b1);
    checkOutput("reset/fields", {outS, outE, outM, outZero, outOvf, outUnf}, '0);
    @(negedge clk);
    rstN = 1'b1;

    applyStimulus(32'h3FC00000, 32'h3FC00000, "1.5x1.5", 1'b1);
    applyStimulus(32'h40000000, 32'hC0400000, "2x-3", 1'b1);
    applyStimulus(32'h00000000, 32'h3F800000, "zero", 1'b1);
    applyStimulus(32'h80000000, 32'h3F800000, "negzero", 1'b1);
    applyStimulus(32'h7F000000, 32'h7F000000, "expovf", 1'b1);
    applyStimulus(32'h00800000, 32'h00800000, "expunf", 1'b1);
    applyStimulus(32'h7F800000, 32'hBF800000, "inf", 1'b1);
    applyStimulus(32'h7F800000, 32'h00000000, "inf*zero", 1'b1);
    applyStimulus(32'h3F800000, 32'h00800000, "minnorm", 1'b1);
    applyStimulus(32'h3FFFFFFF, 32'h3FFFFFFF, "maxmant", 1'b1);

    // Backpressure: the result stays put and stray operands are ignored.
    applyStimulus(32'h3FC00000, 32'h3FC00000, "bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inValid = i[0];
      inA     = $urandom;
      inB     = $urandom;
      @(posedge clk);
      #1;
      checkOutput("bp/in_ready", inReady, 1'b0);
      checkResult("bp");
    end
    // Transfer with in_valid high: the zero operand must wait for IDLE.
    @(negedge clk);
    outReady = 1'b1;
    inValid  = 1'b1;
    inA      = 32'h00000000;
    inB      = 32'h40000000;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    checkOutput("bp/valid after transfer", outValid, 1'b0);
    checkOutput("bp/ready after transfer", inReady, 1'b1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
    computeModel(32'h00000000, 32'h40000000);
    checkResult("bp/next");
    handshake("bp/next");

    // Reset during the multiply loop aborts with no output.
    @(negedge clk);
    inA     = 32'h3FC00000;
    inB     = 32'h3FC00000;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset/valid", outValid, 1'b0);
    checkOutput("midreset/ready", inReady, 1'b1);
    checkOutput("midreset/fields", {outS, outE, outM, outZero, outOvf, outUnf}, '0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("midreset/no output", outValid, 1'b0);
    applyStimulus(32'h3FC00000, 32'h3FC00000, "post-reset", 1'b1);

    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      a[30:23] = 8'($urandom_range(60, 195));
      b[30:23] = 8'($urandom_range(60, 195));
      if ($urandom_range(0, 7) == 0) a[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      if ($urandom_range(0, 7) == 0) b[30:23] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      applyStimulus(a, b, $sformatf("rand%0d", i), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fp_mul_mantissa_core.md
Name: fp_mul_mantissa_core

Overview:
- Sequential front-end of the single-precision FP multiply path.
- Accepts two IEEE-754 binary32 operands and unpacks them.
- Computes the result sign and the biased exponent sum.
- Forms the 48-bit mantissa product with an iterative shift-add multiplier.
- Pre-adjusts the product so the leading one sits at bit 46 or below. Its out_e/out_m feed the multiplication normaliser's in_e/in_m directly downstream.

Parameters:
- EXP_W, 8, exponent field width
- MANT_W, 24, mantissa width including the hidden bit
- BIAS, 127, exponent bias

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands
- in_a  in  32  operand A, binary32
- in_b  in  32  operand B, binary32
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_s  out  1  result sign
- out_e  out  EXP_W  biased exponent to the normaliser
- out_m  out  2*MANT_W  mantissa product to the normaliser
- out_zero  out  1  result is zero
- out_ovf  out  1  exponent overflow, or an Inf/NaN input
- out_unf  out  1  exponent underflow

Behaviour:
- Reset (rst_n low at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_s/out_e/out_m/out_zero/out_ovf/out_unf=0.
  - Reset mid-operation aborts the operation with no output.
- FSM states: IDLE, MUL, ADJ, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid=1 at an edge.
  - On accept, latch sign = a[31]^b[31], ea = a[30:23], eb = b[30:23].
  - Latch mantissas {1,a[22:0]} and {1,b[22:0]}.
  - Compute e_sum = ea+eb-BIAS as a signed EXP_W+2-bit value.
- Special operands, checked at accept in this priority order:
  - ea==0 or eb==0 (zero; denormals flushed to zero) -> go to DONE on the next edge.
    - out_zero=1, out_e=0, out_m=0, out_s=sign.
  - Else ea==255 or eb==255 -> DONE.
    - out_ovf=1, out_e=8'hFF, out_m=0.
  - Else -> MUL. Iteration counter cleared, 48-bit accumulator cleared.
- MUL:
  - One multiplier bit per cycle, LSB first, for exactly MANT_W=24 cycles.
  - If the current multiplier bit is 1, add the multiplicand, shifted by the iteration index, into the accumulator.
  - Counter 0..23; on count 23 -> ADJ.
- ADJ (1 cycle):
  - If product[47]=1: out_m = product>>1, exponent = e_sum+1. Otherwise out_m = product, exponent = e_sum.
  - Exponent > 254 -> out_ovf=1, out_e=8'hFF, out_m=0.
  - Exponent < 1 -> out_unf=1, out_e=0, out_m=0.
  - Otherwise out_e = exponent[7:0].
  - -> DONE.
- DONE:
  - out_valid=1; all outputs held stable.
  - in_ready=0; in_valid is ignored.
  - Transfer when out_ready=1 at an edge, then -> IDLE with out_valid=0.
  - Outputs retain their value until the next result.
- Latency, counted from the accepting edge:
  - Normal path: out_valid high after 26 edges.
  - Zero/special path: out_valid high after 1 edge.
  - No pipelining: one operation in flight.
- Width rules: exponent arithmetic is 10-bit signed, with no wrap before the range check. The product is exactly 48 bits; 24x24 bits cannot overflow.
- Guaranteed invariant: for normal results out_m[47]=0 and out_m[46]=1, so the normaliser only shifts when a later stage makes changes.
- Simultaneous out_ready and in_valid in DONE: the result transfers; the new operand is not accepted until the IDLE cycle.

Decomposition:
- Shared package fp_mul_pkg holds:
  - EXP_W, MANT_W, BIAS constants
  - EXP_MAX=254 and EXP_SPECIAL=8'hFF
  - the FSM state enum (IDLE, MUL, ADJ, DONE)
  - a binary32 field-unpack struct (sign, exp, frac)
- One sub-module, mant_shift_add_mul:
  - 24x24 iterative multiplier with start/busy/done.
  - Its count-23 done pulse moves the parent from MUL to ADJ.
- Exponent logic and the FSM stay in the parent.

Test Plan:
- a=0x3FC00000, b=0x3FC00000 (1.5*1.5) -> after 26 edges: out_s=0, out_e=0x80, out_m=0x480000000000, flags 0.
- a=0x40000000, b=0xC0400000 (2*-3) -> out_s=1, out_e=0x81, out_m=0x600000000000, no bit-47 shift.
- a=0x00000000, b=0x3F800000 -> out_valid after 1 edge: out_zero=1, out_e=0, out_m=0, out_s=0.
- a=b=0x7F000000 -> out_ovf=1, out_e=0xFF, out_m=0. a=b=0x00800000 -> out_unf=1, out_e=0, out_m=0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid, while pulsing in_valid with new operands.
  - Required: outputs stable and in_ready=0 throughout, the new operands are ignored, and a single transfer occurs on out_ready=1.
- Reset mid-MUL: drop rst_n at iteration 10 -> next edge IDLE, out_valid=0, outputs 0. A fresh 1.5*1.5 afterwards gives the first scenario's result.
